// File: rtl/rv64_pipe_core.sv
// rv64_pipe_core: five-stage in-order RV64I subset core (IF/ID/EX/MEM/WB).
// Executes add, sub, and, or, addi, ld, sd and beq; every other opcode is a NOP.
// Instruction memory, 32x64 register file and data memory are all internal.
//
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous, active-low reset
//   final_rd - value driven onto the register-file write port by WB this cycle
//
// Build option: define FORWARDING_EN to add EX-stage operand forwarding
// (EX/MEM first, then MEM/WB). Without it, software must space dependent
// instructions three slots apart and rely on the register-file bypass.
module rv64_pipe_core #(
  parameter int unsigned IMEM_WORDS = 64,
  parameter int unsigned DMEM_WORDS = 64,
  parameter string       IMEM_INIT  = "instructions.hex"
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] final_rd
);

  localparam int unsigned IAW      = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int unsigned DAW      = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [6:0] {
    OP_R    = 7'b0110011,
    OP_ADDI = 7'b0010011,
    OP_LD   = 7'b0000011,
    OP_SD   = 7'b0100011,
    OP_BEQ  = 7'b1100011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_BAD = 4'b1111
  } alu_ctl_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_t;

  // Memories and architectural state
  logic [31:0] imem    [IMEM_WORDS];
  logic [63:0] dmem_q  [DMEM_WORDS];
  logic [63:0] rf_q    [32];
  logic [63:0] pc_q, pc_d;

  // Pipeline registers
  logic [63:0] ifid_pc_q;
  logic [31:0] ifid_inst_q;

  ctrl_t       idex_ctrl_q;
  logic [63:0] idex_pc_q, idex_rs1d_q, idex_rs2d_q, idex_imm_q;
  logic [4:0]  idex_rd_q, idex_rs1_q, idex_rs2_q;
  logic [2:0]  idex_f3_q;
  logic [6:0]  idex_f7_q;

  logic        exmem_reg_write_q, exmem_mem_to_reg_q, exmem_branch_q;
  logic        exmem_mem_read_q, exmem_mem_write_q, exmem_zero_q;
  logic [63:0] exmem_alu_q, exmem_store_q, exmem_baddr_q;
  logic [4:0]  exmem_rd_q;

  logic        memwb_reg_write_q, memwb_mem_to_reg_q;
  logic [63:0] memwb_alu_q, memwb_load_q;
  logic [4:0]  memwb_rd_q;

  // ---------------- IF ----------------
  logic [61:0] pc_word;
  logic [31:0] if_inst;
  logic        branch_taken;

  assign pc_word = pc_q[63:2];
  assign if_inst = (pc_word < 62'(IMEM_WORDS)) ? imem[pc_word[IAW-1:0]] : NOP_INSN;
  assign pc_d    = branch_taken ? exmem_baddr_q : pc_q + 64'd4;

  // ---------------- ID ----------------
  logic [6:0]  id_opcode, id_f7;
  logic [4:0]  id_rd, id_rs1, id_rs2;
  logic [2:0]  id_f3;
  ctrl_t       idex_ctrl_d;
  logic [63:0] idex_imm_d, idex_rs1d_d, idex_rs2d_d;
  logic [63:0] wb_data;
  logic        wb_we;

  assign id_opcode = ifid_inst_q[6:0];
  assign id_rd     = ifid_inst_q[11:7];
  assign id_f3     = ifid_inst_q[14:12];
  assign id_rs1    = ifid_inst_q[19:15];
  assign id_rs2    = ifid_inst_q[24:20];
  assign id_f7     = ifid_inst_q[31:25];

  always_comb begin
    idex_ctrl_d = '0;
    case (id_opcode)
      OP_R:    begin idex_ctrl_d.reg_write = 1'b1; idex_ctrl_d.alu_op = 2'b10; end
      OP_ADDI: begin idex_ctrl_d.reg_write = 1'b1; idex_ctrl_d.alu_src = 1'b1; end
      OP_LD:   begin
        idex_ctrl_d.reg_write  = 1'b1;
        idex_ctrl_d.mem_to_reg = 1'b1;
        idex_ctrl_d.mem_read   = 1'b1;
        idex_ctrl_d.alu_src    = 1'b1;
      end
      OP_SD:   begin idex_ctrl_d.mem_write = 1'b1; idex_ctrl_d.alu_src = 1'b1; end
      OP_BEQ:  begin idex_ctrl_d.branch = 1'b1; idex_ctrl_d.alu_op = 2'b01; end
      default: idex_ctrl_d = '0;
    endcase
  end

  // Branch immediate is a halfword offset; EX doubles it.
  always_comb begin
    idex_imm_d = '0;
    case (id_opcode)
      OP_ADDI, OP_LD: idex_imm_d = {{52{ifid_inst_q[31]}}, ifid_inst_q[31:20]};
      OP_SD:          idex_imm_d = {{52{ifid_inst_q[31]}}, ifid_inst_q[31:25], ifid_inst_q[11:7]};
      OP_BEQ:         idex_imm_d = {{52{ifid_inst_q[31]}}, ifid_inst_q[31], ifid_inst_q[7],
                                    ifid_inst_q[30:25], ifid_inst_q[11:8]};
      default:        idex_imm_d = '0;
    endcase
  end

  // Write-before-read: a register being written by WB this cycle reads as write_data.
  assign wb_we = memwb_reg_write_q && (memwb_rd_q != 5'd0);

  always_comb begin
    idex_rs1d_d = '0;
    idex_rs2d_d = '0;
    if (id_rs1 != 5'd0) idex_rs1d_d = (wb_we && memwb_rd_q == id_rs1) ? wb_data : rf_q[id_rs1];
    if (id_rs2 != 5'd0) idex_rs2d_d = (wb_we && memwb_rd_q == id_rs2) ? wb_data : rf_q[id_rs2];
  end

  // ---------------- EX ----------------
  logic [63:0] ex_op_a, ex_rs2_val, ex_op_b, ex_alu, ex_baddr;
  alu_ctl_e    ex_alu_ctl;
  logic        unused_bits;

`ifdef FORWARDING_EN
  always_comb begin
    ex_op_a    = idex_rs1d_q;
    ex_rs2_val = idex_rs2d_q;
    if (exmem_reg_write_q && exmem_rd_q != 5'd0 && exmem_rd_q == idex_rs1_q)
      ex_op_a = exmem_alu_q;
    else if (wb_we && memwb_rd_q == idex_rs1_q)
      ex_op_a = wb_data;
    if (exmem_reg_write_q && exmem_rd_q != 5'd0 && exmem_rd_q == idex_rs2_q)
      ex_rs2_val = exmem_alu_q;
    else if (wb_we && memwb_rd_q == idex_rs2_q)
      ex_rs2_val = wb_data;
  end
  assign unused_bits = ^pc_q[1:0];
`else
  assign ex_op_a     = idex_rs1d_q;
  assign ex_rs2_val  = idex_rs2d_q;
  assign unused_bits = ^{pc_q[1:0], idex_rs1_q, idex_rs2_q};
`endif

  assign ex_op_b  = idex_ctrl_q.alu_src ? idex_imm_q : ex_rs2_val;
  assign ex_baddr = idex_pc_q + (idex_imm_q << 1);

  always_comb begin
    ex_alu_ctl = ALU_BAD;
    case (idex_ctrl_q.alu_op)
      2'b00: ex_alu_ctl = ALU_ADD;
      2'b01: ex_alu_ctl = ALU_SUB;
      2'b10: begin
        case (idex_f3_q)
          3'b000: begin
            if (idex_f7_q == 7'b0000000)      ex_alu_ctl = ALU_ADD;
            else if (idex_f7_q == 7'b0100000) ex_alu_ctl = ALU_SUB;
            else                              ex_alu_ctl = ALU_BAD;
          end
          3'b111:  ex_alu_ctl = ALU_AND;
          3'b110:  ex_alu_ctl = ALU_OR;
          default: ex_alu_ctl = ALU_BAD;
        endcase
      end
      default: ex_alu_ctl = ALU_BAD;
    endcase
  end

  always_comb begin
    ex_alu = '0;
    case (ex_alu_ctl)
      ALU_ADD: ex_alu = ex_op_a + ex_op_b;
      ALU_SUB: ex_alu = ex_op_a - ex_op_b;
      ALU_AND: ex_alu = ex_op_a & ex_op_b;
      ALU_OR:  ex_alu = ex_op_a | ex_op_b;
      default: ex_alu = '0;
    endcase
  end

  // ---------------- MEM ----------------
  logic [60:0] mem_dword;
  logic        mem_in_range;
  logic [63:0] mem_load;

  assign branch_taken = exmem_branch_q & exmem_zero_q;
  assign mem_dword    = exmem_alu_q[63:3];
  assign mem_in_range = mem_dword < 61'(DMEM_WORDS);
  assign mem_load     = (exmem_mem_read_q && mem_in_range) ? dmem_q[mem_dword[DAW-1:0]] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DMEM_WORDS; i++) dmem_q[i] <= '0;
    end else if (exmem_mem_write_q && mem_in_range) begin
      dmem_q[mem_dword[DAW-1:0]] <= exmem_store_q;
    end
  end

  // ---------------- WB ----------------
  assign wb_data  = memwb_mem_to_reg_q ? memwb_load_q : memwb_alu_q;
  assign final_rd = wb_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_we) begin
      rf_q[memwb_rd_q] <= wb_data;
    end
  end

  // ---------------- Pipeline registers ----------------
  // A taken branch in MEM flushes the three younger stages on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q               <= '0;
      ifid_pc_q          <= '0;
      ifid_inst_q        <= '0;
      idex_ctrl_q        <= '0;
      idex_pc_q          <= '0;
      idex_rs1d_q        <= '0;
      idex_rs2d_q        <= '0;
      idex_imm_q         <= '0;
      idex_rd_q          <= '0;
      idex_rs1_q         <= '0;
      idex_rs2_q         <= '0;
      idex_f3_q          <= '0;
      idex_f7_q          <= '0;
      exmem_reg_write_q  <= 1'b0;
      exmem_mem_to_reg_q <= 1'b0;
      exmem_branch_q     <= 1'b0;
      exmem_mem_read_q   <= 1'b0;
      exmem_mem_write_q  <= 1'b0;
      exmem_zero_q       <= 1'b0;
      exmem_alu_q        <= '0;
      exmem_store_q      <= '0;
      exmem_baddr_q      <= '0;
      exmem_rd_q         <= '0;
      memwb_reg_write_q  <= 1'b0;
      memwb_mem_to_reg_q <= 1'b0;
      memwb_alu_q        <= '0;
      memwb_load_q       <= '0;
      memwb_rd_q         <= '0;
    end else begin
      pc_q               <= pc_d;
      memwb_reg_write_q  <= exmem_reg_write_q;
      memwb_mem_to_reg_q <= exmem_mem_to_reg_q;
      memwb_alu_q        <= exmem_alu_q;
      memwb_load_q       <= mem_load;
      memwb_rd_q         <= exmem_rd_q;
      if (branch_taken) begin
        ifid_pc_q          <= '0;
        ifid_inst_q        <= '0;
        idex_ctrl_q        <= '0;
        idex_pc_q          <= '0;
        idex_rs1d_q        <= '0;
        idex_rs2d_q        <= '0;
        idex_imm_q         <= '0;
        idex_rd_q          <= '0;
        idex_rs1_q         <= '0;
        idex_rs2_q         <= '0;
        idex_f3_q          <= '0;
        idex_f7_q          <= '0;
        exmem_reg_write_q  <= 1'b0;
        exmem_mem_to_reg_q <= 1'b0;
        exmem_branch_q     <= 1'b0;
        exmem_mem_read_q   <= 1'b0;
        exmem_mem_write_q  <= 1'b0;
        exmem_zero_q       <= 1'b0;
        exmem_alu_q        <= '0;
        exmem_store_q      <= '0;
        exmem_baddr_q      <= '0;
        exmem_rd_q         <= '0;
      end else begin
        ifid_pc_q          <= pc_q;
        ifid_inst_q        <= if_inst;
        idex_ctrl_q        <= idex_ctrl_d;
        idex_pc_q          <= ifid_pc_q;
        idex_rs1d_q        <= idex_rs1d_d;
        idex_rs2d_q        <= idex_rs2d_d;
        idex_imm_q         <= idex_imm_d;
        idex_rd_q          <= id_rd;
        idex_rs1_q         <= id_rs1;
        idex_rs2_q         <= id_rs2;
        idex_f3_q          <= id_f3;
        idex_f7_q          <= id_f7;
        exmem_reg_write_q  <= idex_ctrl_q.reg_write;
        exmem_mem_to_reg_q <= idex_ctrl_q.mem_to_reg;
        exmem_branch_q     <= idex_ctrl_q.branch;
        exmem_mem_read_q   <= idex_ctrl_q.mem_read;
        exmem_mem_write_q  <= idex_ctrl_q.mem_write;
        exmem_zero_q       <= (ex_alu == 64'd0);
        exmem_alu_q        <= ex_alu;
        exmem_store_q      <= ex_rs2_val;
        exmem_baddr_q      <= ex_baddr;
        exmem_rd_q         <= idex_rd_q;
      end
    end
  end

endmodule

// File: tb/tb_rv64_pipe_core.sv
// tb_rv64_pipe_core: directed program run on rv64_pipe_core, comparing the
// per-cycle final_rd trace against a hand-computed table, then checking
// register/data-memory contents and asynchronous mid-run reset.
module tb_rv64_pipe_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] final_rd;

  always #5 clk = ~clk;

  rv64_pipe_core #(
    .IMEM_WORDS(64),
    .DMEM_WORDS(64),
    .IMEM_INIT ("")
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .final_rd(final_rd)
  );

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
  endtask

  // Instruction encoders
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input int imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction

  function automatic logic [31:0] ld(input logic [4:0] rd, input int imm, input logic [4:0] rs1);
    return enc_i(imm, rs1, 3'b011, rd, 7'b0000011);
  endfunction

  function automatic logic [31:0] sd(input logic [4:0] rs2, input int imm, input logic [4:0] rs1);
    logic [31:0] v;
    v = imm;
    return {v[11:5], rs2, rs1, 3'b011, v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2, input int off);
    logic [31:0] o;
    o = off;
    return {o[12], o[10:5], rs2, rs1, 3'b000, o[4:1], o[11], 7'b1100011};
  endfunction

  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FORWARDING_EN
  localparam logic [63:0] E_FWD_EXMEM = 64'd6;
  localparam logic [63:0] E_FWD_MEMWB = 64'd4;
  localparam logic [63:0] E_FWD_PRIO  = 64'd2;
`else
  localparam logic [63:0] E_FWD_EXMEM = 64'd0;
  localparam logic [63:0] E_FWD_MEMWB = 64'd0;
  localparam logic [63:0] E_FWD_PRIO  = 64'd0;
`endif

  typedef struct {
    int          k;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] trace[0:63];

  task automatic add_vec(input int k, input logic [63:0] e, input string n);
    vec_t v;
    v.k = k; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] prog[0:38];

    reset = 1'b0;

    prog[0]  = addi(1, 0, 5);
    prog[1]  = addi(2, 0, 7);
    prog[2]  = NOP; prog[3] = NOP; prog[4] = NOP;
    prog[5]  = enc_r(7'b0000000, 2, 1, 3'b000, 3);   // add x3,x1,x2
    prog[6]  = enc_r(7'b0100000, 1, 2, 3'b000, 4);   // sub x4,x2,x1
    prog[7]  = addi(1, 0, 12);
    prog[8]  = addi(2, 0, 10);
    prog[9]  = NOP; prog[10] = NOP; prog[11] = NOP;
    prog[12] = enc_r(7'b0000000, 2, 1, 3'b111, 5);   // and x5,x1,x2
    prog[13] = enc_r(7'b0000000, 2, 1, 3'b110, 6);   // or  x6,x1,x2
    prog[14] = addi(0, 0, 9);
    prog[15] = addi(13, 0, -1);
    prog[16] = addi(2, 0, 7);
    prog[17] = NOP; prog[18] = NOP;
    prog[19] = sd(2, 8, 0);                          // relies on WB->ID bypass
    prog[20] = ld(7, 8, 0);
    prog[21] = beq(1, 1, 16);
    prog[22] = addi(8, 0, 1); prog[23] = addi(8, 0, 1); prog[24] = addi(8, 0, 1);
    prog[25] = addi(9, 0, 'h55);
    prog[26] = beq(1, 2, 8);                         // 12 != 7: not taken
    prog[27] = addi(10, 0, 'h66);
    prog[28] = addi(11, 0, 3);
    prog[29] = enc_r(7'b0000000, 11, 11, 3'b000, 12); // add x12,x11,x11
    prog[30] = sd(13, 512, 0);                       // out of range: ignored
    prog[31] = ld(14, 512, 0);                       // out of range: reads 0
    prog[32] = ld(15, 0, 0);
    prog[33] = addi(16, 0, 4);
    prog[34] = NOP;
    prog[35] = enc_r(7'b0000000, 0, 16, 3'b000, 17); // add x17,x16,x0
    prog[36] = addi(18, 0, 1);
    prog[37] = addi(18, 0, 2);
    prog[38] = enc_r(7'b0000000, 0, 18, 3'b000, 19); // add x19,x18,x0

    for (int i = 0; i < 64; i++) dut.imem[i] = NOP;
    for (int i = 0; i < 39; i++) dut.imem[i] = prog[i];

    // Cycle k = sample taken just after the k-th rising edge following release.
    add_vec(1,  64'd0,  "k1_bubble");
    add_vec(3,  64'd0,  "k3_bubble");
    add_vec(4,  64'd5,  "addi_x1_5");
    add_vec(5,  64'd7,  "addi_x2_7");
    add_vec(6,  64'd0,  "nop_slot");
    add_vec(9,  64'd12, "add_x3");
    add_vec(10, 64'd2,  "sub_x4");
    add_vec(11, 64'd12, "addi_x1_12");
    add_vec(12, 64'd10, "addi_x2_10");
    add_vec(16, 64'd8,  "and_x5");
    add_vec(17, 64'hE,  "or_x6");
    add_vec(18, 64'd9,  "addi_x0_wb");
    add_vec(19, 64'hFFFF_FFFF_FFFF_FFFF, "addi_neg1");
    add_vec(20, 64'd7,  "addi_x2_7b");
    add_vec(23, 64'd8,  "sd_addr");
    add_vec(24, 64'd7,  "ld_x7");
    add_vec(25, 64'd0,  "beq_taken_alu");
    add_vec(26, 64'd0,  "flush_slot1");
    add_vec(27, 64'd0,  "flush_slot2");
    add_vec(28, 64'd0,  "flush_slot3");
    add_vec(29, 64'h55, "branch_target");
    add_vec(30, 64'd5,  "beq_not_taken_alu");
    add_vec(31, 64'h66, "fallthrough");
    add_vec(32, 64'd3,  "addi_x11");
    add_vec(33, E_FWD_EXMEM, "fwd_exmem");
    add_vec(34, 64'd512, "sd_oor_addr");
    add_vec(35, 64'd0,  "ld_oor");
    add_vec(36, 64'd0,  "ld_dmem0");
    add_vec(39, E_FWD_MEMWB, "fwd_memwb");
    add_vec(42, E_FWD_PRIO,  "fwd_priority");

    repeat (3) @(posedge clk);
    #1;
    check("reset_final_rd", final_rd, 64'd0);
    check("reset_pc", dut.pc_q, 64'd0);

    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk);
      #1;
      trace[k] = final_rd;
    end

    foreach (vecs[i]) check(vecs[i].name, trace[vecs[i].k], vecs[i].exp);

    check("x0",  dut.rf_q[0],  64'd0);
    check("x3",  dut.rf_q[3],  64'd12);
    check("x4",  dut.rf_q[4],  64'd2);
    check("x5",  dut.rf_q[5],  64'd8);
    check("x6",  dut.rf_q[6],  64'hE);
    check("x7",  dut.rf_q[7],  64'd7);
    check("x8",  dut.rf_q[8],  64'd0);
    check("x9",  dut.rf_q[9],  64'h55);
    check("x12", dut.rf_q[12], E_FWD_EXMEM);
    check("x14", dut.rf_q[14], 64'd0);
    check("dmem1", dut.dmem_q[1], 64'd7);
    check("dmem0", dut.dmem_q[0], 64'd0);

    // Reset between runs clears register file and data memory.
    reset = 1'b0;
    #1;
    check("rst_x3", dut.rf_q[3], 64'd0);
    check("rst_dmem1", dut.dmem_q[1], 64'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      trace[k] = final_rd;
    end
    check("rerun_k3", trace[3], 64'd0);
    check("rerun_k4", trace[4], 64'd5);
    check("rerun_k10", trace[10], 64'd2);
    check("rerun_x3", dut.rf_q[3], 64'd12);

    // Asynchronous reset in the middle of a clock phase.
    #2;
    reset = 1'b0;
    #1;
    check("async_final_rd", final_rd, 64'd0);
    check("async_x3", dut.rf_q[3], 64'd0);
    check("async_pc", dut.pc_q, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("after_async_first_retire", final_rd, 64'd5);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
